// File: rtl/apb_slave_pkg.sv
// Shared definitions for the APB register slave: FSM encoding, register map
// indices and STATUS bit positions.
package apb_slave_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } apb_state_e;

    localparam int REG_WAIT      = 0;
    localparam int REG_STATUS    = 1;

    localparam int STATUS_ABORT  = 0;
    localparam int STATUS_SLVERR = 1;
    localparam int STATUS_W      = 2;

    localparam int WAIT_W        = 4;

endpackage

// File: rtl/apb_wait_timer.sv
// Wait-state down-counter: loaded with wait_cfg-1 at the setup edge,
// decremented on each access cycle, and reports when it has reached zero.
module apb_wait_timer
    import apb_slave_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WAIT_W-1:0] cfg,
    input  logic              dec,
    output logic              zero
);

    logic [WAIT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            // A cfg of zero wraps here, but the FSM then skips WAIT entirely.
            cnt <= cfg - WAIT_W'(1);
        end else if (dec && cnt != '0) begin
            cnt <= cnt - WAIT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/apb_reg_slave.sv
// APB completer with a byte-wide register file, programmable wait states,
// out-of-range error response and sticky abort/slverr status.
module apb_reg_slave
    import apb_slave_pkg::*;
#(
    parameter int              APB_AW      = 32,
    parameter int              APB_DW      = 8,
    parameter int              NUM_REGS    = 16,
    parameter logic [APB_AW-1:0] BASE_ADDR = '0,
    parameter int              WAIT_STATES = 2
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic [APB_AW-1:0] PADDR,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [APB_DW-1:0] PWDATA,
    output logic [APB_DW-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR
);

    localparam int IDX_W = $clog2(NUM_REGS);

    apb_state_e state_q, state_d;

    logic [WAIT_W-1:0]   wait_cfg;
    logic [STATUS_W-1:0] status;
    logic [APB_DW-1:0]   regs [2:NUM_REGS-1];

    logic [IDX_W-1:0]  idx_q;
    logic              err_q, write_q;
    logic [APB_DW-1:0] wdata_q;

    logic [APB_AW-1:0] off;
    logic [IDX_W-1:0]  in_idx, cur_idx;
    logic              in_err, cur_err, cur_write;
    logic [APB_DW-1:0] rd_val, rdata_d;
    logic              ready_d, slverr_d;

    logic capture, timer_load, timer_dec, timer_zero;
    logic commit, set_abort, set_slverr;
    logic [STATUS_W-1:0] status_set, status_clr;

    assign off    = PADDR - BASE_ADDR;
    assign in_err = (off >= APB_AW'(NUM_REGS));
    assign in_idx = off[IDX_W-1:0];

    // With zero wait states the response is built at the setup edge itself,
    // before the latched copies exist, so use the live decode there.
    assign cur_idx   = capture ? in_idx : idx_q;
    assign cur_err   = capture ? in_err : err_q;
    assign cur_write = capture ? PWRITE : write_q;

    apb_wait_timer u_timer (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .load  (timer_load),
        .cfg   (wait_cfg),
        .dec   (timer_dec),
        .zero  (timer_zero)
    );

    // NOTE: every signal gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        capture    = 1'b0;
        timer_load = 1'b0;
        timer_dec  = 1'b0;
        commit     = 1'b0;
        set_abort  = 1'b0;
        set_slverr = 1'b0;
        case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    capture    = 1'b1;
                    timer_load = 1'b1;
                    state_d    = (wait_cfg == '0) ? RESP : WAIT;
                end else if (PSEL && PENABLE) begin
                    set_abort = 1'b1;
                end
            end
            WAIT: begin
                if (!PSEL) begin
                    state_d   = IDLE;
                    set_abort = 1'b1;
                end else if (PENABLE) begin
                    if (timer_zero) state_d = RESP;
                    else            timer_dec = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                if (!PSEL) begin
                    set_abort = 1'b1;
                end else if (PENABLE) begin
                    commit     = write_q && !err_q;
                    set_slverr = err_q;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d  = (state_d == RESP);
        slverr_d = ready_d && cur_err;
        rdata_d  = (ready_d && !cur_write && !cur_err) ? rd_val : '0;
    end

    always_comb begin
        rd_val = '0;
        if (cur_idx == IDX_W'(REG_WAIT))        rd_val = APB_DW'(wait_cfg);
        else if (cur_idx == IDX_W'(REG_STATUS)) rd_val = APB_DW'(status);
        else                                    rd_val = regs[cur_idx];
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            write_q <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            PREADY  <= ready_d;
            PSLVERR <= slverr_d;
            PRDATA  <= rdata_d;
            if (capture) begin
                idx_q   <= in_idx;
                err_q   <= in_err;
                write_q <= PWRITE;
                wdata_q <= PWDATA;
            end
        end
    end

    always_comb begin
        status_set = '0;
        status_set[STATUS_ABORT]  = set_abort;
        status_set[STATUS_SLVERR] = set_slverr;
        status_clr = (commit && idx_q == IDX_W'(REG_STATUS)) ? wdata_q[STATUS_W-1:0] : '0;
    end

    // NOTE: the register file is a handful of flops, so it is reset like any other state.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wait_cfg <= WAIT_W'(WAIT_STATES);
            status   <= '0;
            for (int i = 2; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            // A simultaneous set beats the write-1-to-clear.
            status <= (status & ~status_clr) | status_set;
            if (commit && idx_q == IDX_W'(REG_WAIT)) wait_cfg <= wdata_q[WAIT_W-1:0];
            if (commit && idx_q >= IDX_W'(2))        regs[idx_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed self-checking bench for apb_reg_slave: wait states, decode errors,
// sticky status, aborts, mid-transfer reset and back-to-back transfers.
module tb_apb_reg_slave;

    localparam logic [31:0] BASE = 32'h40;

    logic        PCLK;
    logic        PRESETn;
    logic [31:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [7:0]  PWDATA;
    logic [7:0]  PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int n_checks = 0;
    int n_fail   = 0;

    apb_reg_slave #(
        .APB_AW      (32),
        .APB_DW      (8),
        .NUM_REGS    (16),
        .BASE_ADDR   (BASE),
        .WAIT_STATES (2)
    ) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .PADDR   (PADDR),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // One complete APB transfer; PWDATA is scrambled after setup to prove it was captured.
    task automatic transact(input string tag, input logic wr, input logic [31:0] addr,
                            input logic [7:0] data, input logic [7:0] exp_rdata,
                            input logic exp_err, input int exp_waits);
        int waits;
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = addr;
        PWDATA  = data;
        tick();
        PENABLE = 1'b1;
        PWDATA  = ~data;
        waits   = 0;
        while (!PREADY && waits < 40) begin
            tick();
            waits++;
        end
        check({tag, " ready"}, 32'(PREADY), 32'd1);
        check({tag, " waits"}, 32'(waits), 32'(exp_waits));
        check({tag, " rdata"}, 32'(PRDATA), 32'(exp_rdata));
        check({tag, " slverr"}, 32'(PSLVERR), 32'(exp_err));
        tick();
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        check({tag, " drop"}, 32'(PREADY), 32'd0);
    endtask

    initial begin
        PRESETn = 1'b0;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = '0;
        PWDATA  = '0;
        repeat (3) tick();
        check("rst ready", 32'(PREADY), 32'd0);
        check("rst rdata", 32'(PRDATA), 32'd0);
        check("rst slverr", 32'(PSLVERR), 32'd0);
        PRESETn = 1'b1;
        tick();

        // Reset wait count of 2, then zero wait states.
        transact("rd_wait_rst", 1'b0, BASE + 0, 8'h00, 8'h02, 1'b0, 2);
        transact("wr_wait0",    1'b1, BASE + 0, 8'h00, 8'h00, 1'b0, 2);
        transact("wr_r5",       1'b1, BASE + 5, 8'hA5, 8'h00, 1'b0, 0);
        transact("rd_r5",       1'b0, BASE + 5, 8'h00, 8'hA5, 1'b0, 0);

        // Decode errors and sticky slverr.
        transact("rd_oob",      1'b0, BASE + 16, 8'h00, 8'h00, 1'b1, 0);
        transact("rd_stat_se",  1'b0, BASE + 1,  8'h00, 8'h02, 1'b0, 0);
        transact("clr_slverr",  1'b1, BASE + 1,  8'h02, 8'h00, 1'b0, 0);
        transact("rd_stat_clr", 1'b0, BASE + 1,  8'h00, 8'h00, 1'b0, 0);
        transact("rd_below",    1'b0, BASE - 1,  8'h00, 8'h00, 1'b1, 0);
        transact("wr_r15",      1'b1, BASE + 15, 8'h7E, 8'h00, 1'b0, 0);
        transact("rd_r15",      1'b0, BASE + 15, 8'h00, 8'h7E, 1'b0, 0);
        transact("rd_stat2",    1'b0, BASE + 1,  8'h00, 8'h02, 1'b0, 0);
        transact("wr_oob",      1'b1, BASE + 16, 8'h99, 8'h00, 1'b1, 0);
        transact("clr_all",     1'b1, BASE + 1,  8'hFF, 8'h00, 1'b0, 0);
        transact("rd_stat3",    1'b0, BASE + 1,  8'h00, 8'h00, 1'b0, 0);

        // WAIT keeps only its low nibble; new value applies from the next transfer.
        transact("wr_wait_f3",  1'b1, BASE + 0, 8'hF3, 8'h00, 1'b0, 0);
        transact("rd_wait_f3",  1'b0, BASE + 0, 8'h00, 8'h03, 1'b0, 3);
        transact("wr_wait2",    1'b1, BASE + 0, 8'h02, 8'h00, 1'b0, 3);

        // PSEL dropped during WAIT: no write, abort recorded.
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = 1'b1;
        PADDR   = BASE + 7;
        PWDATA  = 8'h3C;
        tick();
        PENABLE = 1'b1;
        check("abort acc ready", 32'(PREADY), 32'd0);
        tick();
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        check("abort wait ready", 32'(PREADY), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort idle ready", 32'(PREADY), 32'd0);
        end
        transact("rd_r7",        1'b0, BASE + 7, 8'h00, 8'h00, 1'b0, 2);
        transact("rd_stat_ab",   1'b0, BASE + 1, 8'h00, 8'h01, 1'b0, 2);
        transact("clr_abort",    1'b1, BASE + 1, 8'h01, 8'h00, 1'b0, 2);
        transact("rd_stat_ab0",  1'b0, BASE + 1, 8'h00, 8'h00, 1'b0, 2);

        // Access phase without setup in IDLE: protocol violation.
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        PWRITE  = 1'b0;
        PADDR   = BASE + 2;
        tick();
        check("viol ready", 32'(PREADY), 32'd0);
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        tick();
        check("viol ready2", 32'(PREADY), 32'd0);
        transact("rd_stat_viol", 1'b0, BASE + 1, 8'h00, 8'h01, 1'b0, 2);
        transact("clr_viol",     1'b1, BASE + 1, 8'h01, 8'h00, 1'b0, 2);

        // Reset asserted during WAIT of a write to index 3.
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = 1'b1;
        PADDR   = BASE + 3;
        PWDATA  = 8'hFF;
        tick();
        PENABLE = 1'b1;
        tick();
        PRESETn = 1'b0;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        #1;
        check("mid_rst ready", 32'(PREADY), 32'd0);
        check("mid_rst rdata", 32'(PRDATA), 32'd0);
        check("mid_rst slverr", 32'(PSLVERR), 32'd0);
        tick();
        PRESETn = 1'b1;
        tick();
        transact("rd_r3_rst",   1'b0, BASE + 3, 8'h00, 8'h00, 1'b0, 2);
        transact("rd_wait_rst2",1'b0, BASE + 0, 8'h00, 8'h02, 1'b0, 2);
        transact("rd_stat_rst", 1'b0, BASE + 1, 8'h00, 8'h00, 1'b0, 2);

        // Back-to-back transfers with one wait state.
        transact("wr_wait1", 1'b1, BASE + 0, 8'h01, 8'h00, 1'b0, 2);
        transact("b2b_wr2",  1'b1, BASE + 2, 8'h11, 8'h00, 1'b0, 1);
        transact("b2b_wr3",  1'b1, BASE + 3, 8'h22, 8'h00, 1'b0, 1);
        transact("b2b_rd2",  1'b0, BASE + 2, 8'h00, 8'h11, 1'b0, 1);
        transact("b2b_rd3",  1'b0, BASE + 3, 8'h00, 8'h22, 1'b0, 1);

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
